// File: rtl/rtc_edit_pkg.sv
// Shared types and defaults for the RTC field editor.
// Holds the session state type, default field layout and the field adjust rule.
package rtc_edit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int N_FIELDS_D = 6;
    localparam int VAL_W_D    = 7;
    localparam int IDX_W_D    = 3;

    localparam int SEC_IDX    = 0;
    localparam int MIN_IDX    = 1;
    localparam int HOUR_IDX_D = 2;
    localparam int DAY_IDX    = 3;
    localparam int MON_IDX    = 4;
    localparam int YEAR_IDX   = 5;

    localparam logic [5:0] MIN_ONE_MASK_D = 6'b011000;
    localparam int         TIMEOUT_TK_D   = 10;

    localparam int PB_W     = 5;
    localparam int PB_LEFT  = 0;
    localparam int PB_RIGHT = 1;
    localparam int PB_UP    = 2;
    localparam int PB_DOWN  = 3;
    localparam int PB_PROG  = 4;

    localparam int ADJ_W = 16;

    // Up wraps max -> min; down wraps min -> max and pulls any
    // out-of-range value (e.g. after a 12/24 h switch) back to max.
    function automatic logic [ADJ_W-1:0] fld_adjust(
        input logic [ADJ_W-1:0] v,
        input logic [ADJ_W-1:0] mn,
        input logic [ADJ_W-1:0] mx,
        input logic             up,
        input logic             dn
    );
        logic [ADJ_W-1:0] r;
        r = v;
        if (up && !dn)
            r = (v >= mx) ? mn : v + ADJ_W'(1);
        else if (dn && !up)
            r = (v <= mn || v > mx) ? mx : v - ADJ_W'(1);
        return r;
    endfunction

endpackage

// File: rtl/pb_edge_det.sv
// Rising-edge press detector for the debounced push-button levels.
// Ports: clk, reset (async high), pb levels in, press pulses out.
module pb_edge_det
    import rtc_edit_pkg::*;
#(
    parameter int W = PB_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] pb,
    output logic [W-1:0] press
);

    logic [W-1:0] hist;

    // History resets high so a button held through reset is not a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hist <= '1;
        else
            hist <= pb;
    end

    assign press = pb & ~hist;

endmodule

// File: rtl/rtc_field_editor.sv
// Edit session controller for N time/date fields of an RTC.
// Ports: clk/reset, start, push-buttons, mode_12h, timeout_tick,
// load_data/max_bus in; busy, cursor, edit_data, wr_*, done, aborted out.
module rtc_field_editor
    import rtc_edit_pkg::*;
#(
    parameter int                    N_FIELDS     = N_FIELDS_D,
    parameter int                    VAL_W        = VAL_W_D,
    parameter int                    IDX_W        = IDX_W_D,
    parameter int                    HOUR_IDX     = HOUR_IDX_D,
    parameter logic [N_FIELDS-1:0]   MIN_ONE_MASK = MIN_ONE_MASK_D,
    parameter int                    TIMEOUT_TK   = TIMEOUT_TK_D
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pb_left,
    input  logic                      pb_right,
    input  logic                      pb_up,
    input  logic                      pb_down,
    input  logic                      pb_program,
    input  logic                      mode_12h,
    input  logic                      timeout_tick,
    input  logic [N_FIELDS*VAL_W-1:0] load_data,
    input  logic [N_FIELDS*VAL_W-1:0] max_bus,
    output logic                      busy,
    output logic [IDX_W-1:0]          cursor,
    output logic [N_FIELDS*VAL_W-1:0] edit_data,
    output logic                      wr_en,
    output logic [IDX_W-1:0]          wr_addr,
    output logic [VAL_W-1:0]          wr_data,
    output logic                      done,
    output logic                      aborted
);

    localparam int TMR_W = $clog2(TIMEOUT_TK + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_FIELDS - 1);

    state_t             state;
    logic [VAL_W-1:0]   fld [N_FIELDS];
    logic [VAL_W-1:0]   mx  [N_FIELDS];
    logic [IDX_W-1:0]   k;
    logic [TMR_W-1:0]   timer;
    logic [PB_W-1:0]    press;
    logic [VAL_W-1:0]   lo;
    logic [VAL_W-1:0]   hi;
    logic [VAL_W-1:0]   nxt;
    logic               lr_act;
    logic               ud_act;

    pb_edge_det #(.W(PB_W)) u_pb (
        .clk   (clk),
        .reset (reset),
        .pb    ({pb_program, pb_down, pb_up, pb_right, pb_left}),
        .press (press)
    );

    for (genvar g = 0; g < N_FIELDS; g++) begin : g_fld
        assign edit_data[g*VAL_W +: VAL_W] = fld[g];
        assign mx[g] = max_bus[g*VAL_W +: VAL_W];
    end

    assign lr_act = press[PB_LEFT] | press[PB_RIGHT];
    assign ud_act = press[PB_UP]   | press[PB_DOWN];

    // Limits of the field under the cursor; 12 h mode overrides the hour.
    always_comb begin
        lo = VAL_W'(MIN_ONE_MASK[cursor]);
        hi = mx[cursor];
        if (mode_12h && cursor == IDX_W'(HOUR_IDX)) begin
            lo = VAL_W'(1);
            hi = VAL_W'(12);
        end
        nxt = VAL_W'(fld_adjust(ADJ_W'(fld[cursor]), ADJ_W'(lo),
                                ADJ_W'(hi), press[PB_UP],
                                press[PB_DOWN]));
    end

    assign busy    = (state == EDIT) || (state == COMMIT);
    assign wr_en   = (state == COMMIT);
    assign wr_addr = wr_en ? k : '0;
    assign wr_data = wr_en ? fld[k] : '0;
    assign done    = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cursor  <= '0;
            k       <= '0;
            timer   <= '0;
            aborted <= 1'b0;
            for (int i = 0; i < N_FIELDS; i++)
                fld[i] <= '0;
        end else begin
            aborted <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N_FIELDS; i++)
                            fld[i] <= load_data[i*VAL_W +: VAL_W];
                        cursor <= '0;
                        timer  <= '0;
                        state  <= EDIT;
                    end
                end
                EDIT: begin
                    if (press[PB_PROG]) begin
                        k     <= '0;
                        timer <= '0;
                        state <= COMMIT;
                    end else if (lr_act) begin
                        timer <= '0;
                        if (press[PB_LEFT] && !press[PB_RIGHT])
                            cursor <= (cursor == LAST) ? '0 : cursor + IDX_W'(1);
                        else if (press[PB_RIGHT] && !press[PB_LEFT])
                            cursor <= (cursor == '0) ? LAST : cursor - IDX_W'(1);
                    end else if (ud_act) begin
                        timer       <= '0;
                        fld[cursor] <= nxt;
                    end else if (timeout_tick) begin
                        if (timer == TMR_W'(TIMEOUT_TK - 1)) begin
                            timer   <= '0;
                            aborted <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    if (k == LAST)
                        state <= DONE;
                    else
                        k <= k + IDX_W'(1);
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_field_editor.sv
// Self-checking bench for rtc_field_editor.
// Table vectors, hand sequences and a randomized run against a reference model.
module tb_rtc_field_editor;

    localparam int NF = 6;
    localparam int VW = 7;
    localparam int TO = 10;
    localparam logic [4:0] B_L = 5'b00001;
    localparam logic [4:0] B_R = 5'b00010;
    localparam logic [4:0] B_U = 5'b00100;
    localparam logic [4:0] B_D = 5'b01000;
    localparam logic [4:0] B_P = 5'b10000;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [4:0]      pb = '0;
    logic            mode_12h = 1'b0;
    logic            tick = 1'b0;
    logic [NF*VW-1:0] load_data = '0;
    logic [NF*VW-1:0] max_bus;
    logic            busy;
    logic [2:0]      cursor;
    logic [NF*VW-1:0] edit_data;
    logic            wr_en;
    logic [2:0]      wr_addr;
    logic [VW-1:0]   wr_data;
    logic            done;
    logic            aborted;

    int n_chk = 0;
    int n_pass = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int maxv [NF] = '{59, 59, 23, 31, 12, 99};
    int minv [NF] = '{0, 0, 0, 1, 1, 0};

    rtc_field_editor dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pb_left      (pb[0]),
        .pb_right     (pb[1]),
        .pb_up        (pb[2]),
        .pb_down      (pb[3]),
        .pb_program   (pb[4]),
        .mode_12h     (mode_12h),
        .timeout_tick (tick),
        .load_data    (load_data),
        .max_bus      (max_bus),
        .busy         (busy),
        .cursor       (cursor),
        .edit_data    (edit_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .done         (done),
        .aborted      (aborted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) wr_cnt++;
        if (done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        tick = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic begin_session(input logic [NF*VW-1:0] ld);
        load_data = ld;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic press(input logic [4:0] m);
        pb = m;
        step();
        pb = '0;
        step();
    endtask

    function automatic int fget(input int f);
        logic [VW-1:0] v;
        v = edit_data[f*VW +: VW];
        return int'(v);
    endfunction

    // Reference arithmetic: the legal range is a cycle of span values.
    function automatic int lo_of(input int f, input bit m12);
        return (f == 2 && m12) ? 1 : minv[f];
    endfunction

    function automatic int hi_of(input int f, input bit m12);
        return (f == 2 && m12) ? 12 : maxv[f];
    endfunction

    function automatic int ref_up(input int v, input int lo, input int hi);
        int span;
        span = hi - lo + 1;
        if (v >= lo && v <= hi) return lo + (v - lo + 1) % span;
        return lo;
    endfunction

    function automatic int ref_dn(input int v, input int lo, input int hi);
        int span;
        span = hi - lo + 1;
        if (v >= lo && v <= hi) return lo + (v - lo - 1 + span) % span;
        return hi;
    endfunction

    typedef struct {
        int         f;
        int         v;
        bit         m12;
        logic [4:0] btn;
        int         exp;
    } vec_t;

    vec_t tbl [12];

    // Behavioural model state for the randomized run.
    int         m_st;
    int         m_v [NF];
    int         m_cur;
    int         m_tmr;
    int         m_k;
    bit         m_ab;
    logic [4:0] m_prev;

    task automatic model_reset();
        m_st = 0;
        m_cur = 0;
        m_tmr = 0;
        m_k = 0;
        m_ab = 1'b0;
        m_prev = '1;
        for (int i = 0; i < NF; i++) m_v[i] = 0;
    endtask

    task automatic model_step();
        logic [4:0] pr;
        pr = pb & ~m_prev;
        m_prev = pb;
        m_ab = 1'b0;
        case (m_st)
            0: if (start) begin
                for (int i = 0; i < NF; i++)
                    m_v[i] = int'(load_data[i*VW +: VW]);
                m_cur = 0;
                m_tmr = 0;
                m_st = 1;
            end
            1: begin
                if (pr[4]) begin
                    m_st = 2;
                    m_k = 0;
                end else if (pr[0] || pr[1]) begin
                    m_tmr = 0;
                    if (pr[0] && !pr[1]) m_cur = (m_cur + 1) % NF;
                    if (pr[1] && !pr[0]) m_cur = (m_cur + NF - 1) % NF;
                end else if (pr[2] || pr[3]) begin
                    m_tmr = 0;
                    if (pr[2] && !pr[3])
                        m_v[m_cur] = ref_up(m_v[m_cur], lo_of(m_cur, mode_12h),
                                            hi_of(m_cur, mode_12h));
                    if (pr[3] && !pr[2])
                        m_v[m_cur] = ref_dn(m_v[m_cur], lo_of(m_cur, mode_12h),
                                            hi_of(m_cur, mode_12h));
                end else if (tick) begin
                    m_tmr++;
                    if (m_tmr == TO) begin
                        m_tmr = 0;
                        m_ab = 1'b1;
                        m_st = 0;
                    end
                end
            end
            2: if (m_k == NF - 1) m_st = 3; else m_k++;
            default: m_st = 0;
        endcase
    endtask

    initial begin
        logic [NF*VW-1:0] ld;
        logic [NF*VW-1:0] exp_ed;
        logic [16:0]      act_c;
        logic [16:0]      exp_c;
        bit               we;
        int               wseen;

        for (int i = 0; i < NF; i++) max_bus[i*VW +: VW] = VW'(maxv[i]);

        tbl[0]  = '{rtc_edit_pkg::SEC_IDX,  59, 1'b0, B_U, 0};
        tbl[1]  = '{rtc_edit_pkg::SEC_IDX,  0,  1'b0, B_D, 59};
        tbl[2]  = '{rtc_edit_pkg::HOUR_IDX_D, 12, 1'b1, B_U, 1};
        tbl[3]  = '{rtc_edit_pkg::HOUR_IDX_D, 15, 1'b1, B_D, 12};
        tbl[4]  = '{rtc_edit_pkg::HOUR_IDX_D, 23, 1'b0, B_U, 0};
        tbl[5]  = '{rtc_edit_pkg::DAY_IDX,  1,  1'b0, B_D, 31};
        tbl[6]  = '{rtc_edit_pkg::DAY_IDX,  31, 1'b0, B_U, 1};
        tbl[7]  = '{rtc_edit_pkg::MON_IDX,  12, 1'b0, B_U, 1};
        tbl[8]  = '{rtc_edit_pkg::MON_IDX,  0,  1'b0, B_D, 12};
        tbl[9]  = '{rtc_edit_pkg::YEAR_IDX, 99, 1'b0, B_U, 0};
        tbl[10] = '{rtc_edit_pkg::HOUR_IDX_D, 0, 1'b1, B_U, 1};
        tbl[11] = '{rtc_edit_pkg::MIN_IDX,  30, 1'b0, B_U | B_D, 30};

        // Reset state
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_edit_data", edit_data, 0);
        chk("rst_wr", {wr_en, wr_addr, wr_data}, 0);
        chk("rst_done_abort", {done, aborted}, 0);

        // Table vectors
        for (int t = 0; t < 12; t++) begin
            do_reset();
            mode_12h = tbl[t].m12;
            ld = '0;
            for (int i = 0; i < NF; i++) ld[i*VW +: VW] = VW'(5);
            ld[tbl[t].f*VW +: VW] = VW'(tbl[t].v);
            begin_session(ld);
            for (int i = 0; i < tbl[t].f; i++) press(B_L);
            chk($sformatf("vec%0d_cursor", t), cursor, tbl[t].f);
            press(tbl[t].btn);
            chk($sformatf("vec%0d_value", t), fget(tbl[t].f), tbl[t].exp);
        end
        mode_12h = 1'b0;

        // Cursor wrap and simultaneous left/right
        do_reset();
        begin_session('0);
        press(B_R);
        chk("right_wrap", cursor, 5);
        press(B_L);
        chk("left_wrap", cursor, 0);
        press(B_L | B_R);
        chk("lr_same", cursor, 0);
        chk("busy_edit", busy, 1);

        // Button held through reset is not a press
        pb = B_U;
        do_reset();
        ld = '0;
        ld[0 +: VW] = VW'(7);
        begin_session(ld);
        step();
        step();
        chk("held_reset", fget(0), 7);
        pb = '0;
        step();

        // Commit sequence
        do_reset();
        for (int i = 0; i < NF; i++) ld[i*VW +: VW] = VW'(10 * i + 3);
        begin_session(ld);
        press(B_U);
        wr_cnt = 0;
        done_cnt = 0;
        pb = B_P;
        step();
        pb = '0;
        for (int i = 0; i < NF; i++) begin
            chk($sformatf("commit_en%0d", i), wr_en, 1);
            chk($sformatf("commit_addr%0d", i), wr_addr, i);
            chk($sformatf("commit_data%0d", i), wr_data,
                (i == 0) ? 4 : 10 * i + 3);
            step();
        end
        chk("commit_done", {done, busy, wr_en}, 3'b100);
        step();
        chk("done_pulse", done, 0);
        chk("wr_count", wr_cnt, NF);
        chk("done_count", done_cnt, 1);

        // Inactivity abort, restarted by a press on a tick
        do_reset();
        begin_session('0);
        wr_cnt = 0;
        for (int i = 0; i < TO - 1; i++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        chk("to_9_busy", {busy, aborted}, 2'b10);
        pb = B_U;
        tick = 1'b1;
        step();
        pb = '0;
        tick = 1'b0;
        step();
        for (int i = 0; i < TO - 1; i++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        chk("to_restart", {busy, aborted}, 2'b10);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("to_abort", {busy, aborted}, 2'b01);
        step();
        chk("to_abort_pulse", aborted, 0);
        chk("to_no_write", wr_cnt, 0);

        // Reset in the middle of a commit
        do_reset();
        begin_session(ld);
        done_cnt = 0;
        pb = B_P;
        step();
        pb = '0;
        step();
        step();
        step();
        chk("mid_commit_addr", wr_addr, 3);
        reset = 1'b1;
        #1;
        chk("async_rst", {wr_en, busy}, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("no_done_after_rst", done_cnt, 0);

        // Randomized run against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit quiet;
            quiet = ((c / 64) % 3) == 0;
            pb = '0;
            if (!quiet) begin
                pb[3:0] = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                pb[4] = ($urandom_range(0, 59) == 0);
            end
            tick = ($urandom_range(0, 1) == 1);
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) mode_12h = ~mode_12h;
            for (int i = 0; i < NF; i++)
                load_data[i*VW +: VW] = VW'($urandom_range(0, 127));
            model_step();
            step();
            we = (m_st == 2);
            wseen = we ? m_v[m_k] : 0;
            exp_c = {m_st == 1 || m_st == 2, 3'(m_cur), we,
                     we ? 3'(m_k) : 3'd0, 7'(wseen), m_st == 3, m_ab};
            act_c = {busy, cursor, wr_en, wr_addr, wr_data, done, aborted};
            for (int i = 0; i < NF; i++) exp_ed[i*VW +: VW] = VW'(m_v[i]);
            chk($sformatf("rnd_ctrl_c%0d", c), act_c, exp_c);
            chk($sformatf("rnd_data_c%0d", c), edit_data, exp_ed);
            if (m_st == 3) m_st = 3;
        end
        start = 1'b0;
        pb = '0;
        tick = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
